// File: rtl/sumador_sg_mag_pipe.sv
// sumador_sg_mag_pipe
//   Two-stage pipelined sign-magnitude adder/subtractor with valid/ready
//   handshakes on both sides. Operands are W bits wide with the MSB as the
//   sign and the low M = W-1 bits as the magnitude.
//
//   Stage 1 orders the operands by magnitude and works out the effective
//   operation and result sign. Stage 2 adds or subtracts the magnitudes,
//   flags overflow, applies saturation or wrap, and normalises -0 to +0.
//
// Parameters
//   W    total operand width including the sign bit (W >= 3)
//   SAT  1: saturate the magnitude to all-ones on overflow, 0: wrap
//
// Ports
//   clk        in   1     system clock, rising edge
//   reset      in   1     asynchronous active-high reset
//   in_valid   in   1     operand beat valid
//   in_ready   out  1     unit can accept a beat this cycle
//   op         in   1     0: a+b, 1: a-b
//   a          in   W     operand A, sign-magnitude
//   b          in   W     operand B, sign-magnitude
//   out_valid  out  1     result beat valid
//   out_ready  in   1     downstream accepts the result this cycle
//   res        out  W-1   result magnitude
//   sg         out  1     result sign (1 = negative)
//   ovf        out  1     magnitude overflow on this result
module sumador_sg_mag_pipe #(
  parameter int W   = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-2:0] res,
  output logic         sg,
  output logic         ovf
);

  localparam int M = W - 1;

  // Pipeline occupancy and stage enables
  logic v1;
  logic v2;
  logic en1;
  logic en2;

  // A stage may load when it is empty or when the stage after it moves on.
  // in_ready is deliberately independent of in_valid.
  assign en2       = !v2 || out_ready;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v2;

  // Stage 1: operand ordering
  logic [M-1:0] mag_a;
  logic [M-1:0] mag_b;
  logic         sign_a;
  logic         sign_b_eff;
  logic         a_is_larger;
  logic [M-1:0] large_d;
  logic [M-1:0] small_d;
  logic         sign_d;
  logic         eff_sub_d;

  // Subtraction is folded into B's sign. Ties pick A as the larger operand,
  // so a tie with opposite signs yields zero that is normalised later.
  always_comb begin
    mag_a       = a[M-1:0];
    mag_b       = b[M-1:0];
    sign_a      = a[W-1];
    sign_b_eff  = b[W-1] ^ op;
    a_is_larger = (mag_a >= mag_b);
    large_d     = a_is_larger ? mag_a : mag_b;
    small_d     = a_is_larger ? mag_b : mag_a;
    sign_d      = a_is_larger ? sign_a : sign_b_eff;
    eff_sub_d   = sign_a ^ sign_b_eff;
  end

  logic [M-1:0] s1_large;
  logic [M-1:0] s1_small;
  logic         s1_sign;
  logic         s1_eff_sub;

  // Payload is loaded only with a real beat; a bubble just clears v1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1         <= 1'b0;
      s1_large   <= '0;
      s1_small   <= '0;
      s1_sign    <= 1'b0;
      s1_eff_sub <= 1'b0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_large   <= large_d;
        s1_small   <= small_d;
        s1_sign    <= sign_d;
        s1_eff_sub <= eff_sub_d;
      end
    end
  end

  // Stage 2: magnitude arithmetic
  logic [M:0]   sum_ext;
  logic [M-1:0] diff;
  logic [M-1:0] mag_d;
  logic         ovf_d;
  logic         sg_d;

  // Like signs: the sign is shared, so the larger operand's sign equals A's.
  // Unlike signs: larger minus smaller can never go negative or overflow.
  always_comb begin
    sum_ext = {1'b0, s1_large} + {1'b0, s1_small};
    diff    = s1_large - s1_small;
    mag_d   = '0;
    ovf_d   = 1'b0;
    if (s1_eff_sub) begin
      mag_d = diff;
      ovf_d = 1'b0;
    end else begin
      mag_d = sum_ext[M-1:0];
      ovf_d = sum_ext[M];
    end
    if (ovf_d && SAT) begin
      mag_d = '1;
    end
    // A zero magnitude is always reported as +0.
    sg_d = (mag_d == '0) ? 1'b0 : s1_sign;
  end

  // Output registers hold their value while stalled (en2 low).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2  <= 1'b0;
      res <= '0;
      sg  <= 1'b0;
      ovf <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        res <= mag_d;
        sg  <= sg_d;
        ovf <= ovf_d;
      end
    end
  end

  // A stalled result must stay on the bus unchanged until it is taken.
  a_hold_stable: assert property (
    @(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=>
        (out_valid && $stable(res) && $stable(sg) && $stable(ovf))
  );

endmodule

// File: tb/tb_sumador_sg_mag_pipe.sv
// tb_sumador_sg_mag_pipe
//   Self-checking bench for sumador_sg_mag_pipe. Two instances share all
//   inputs: one saturating (SAT=1), one wrapping (SAT=0). Expected results
//   come from integer arithmetic on signed values and from constant tables.
module tb_sumador_sg_mag_pipe;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_ready;

  logic       in_ready_s;
  logic       out_valid_s;
  logic [6:0] res_s;
  logic       sg_s;
  logic       ovf_s;

  logic       in_ready_w;
  logic       out_valid_w;
  logic [6:0] res_w;
  logic       sg_w;
  logic       ovf_w;

  logic [8:0] got_s;
  logic [8:0] got_w;
  assign got_s = {ovf_s, sg_s, res_s};
  assign got_w = {ovf_w, sg_w, res_w};

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [8:0] s;
    logic [8:0] w;
  } exp_t;

  sumador_sg_mag_pipe #(.W(W), .SAT(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .res(res_s), .sg(sg_s), .ovf(ovf_s)
  );

  sumador_sg_mag_pipe #(.W(W), .SAT(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .op(op), .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .res(res_w), .sg(sg_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer arithmetic, then sign-magnitude encoding.
  // Returns {ovf, sign, magnitude}.
  function automatic logic [8:0] ref_result(logic [7:0] ra, logic [7:0] rb,
                                            logic rop, bit sat);
    int sa, sb, r, mag;
    logic s, o;
    logic [6:0] ma, mb;
    ma  = ra[6:0];
    mb  = rb[6:0];
    sa  = ra[7] ? -int'(ma) : int'(ma);
    sb  = rb[7] ? -int'(mb) : int'(mb);
    if (rop) sb = -sb;
    r   = sa + sb;
    s   = (r < 0);
    mag = (r < 0) ? -r : r;
    o   = (mag > 127);
    if (o) mag = sat ? 127 : (mag % 128);
    if (mag == 0) s = 1'b0;
    return {o, s, 7'(mag)};
  endfunction

  function automatic exp_t ref_pair(logic [7:0] ra, logic [7:0] rb, logic rop);
    exp_t e;
    e.s = ref_result(ra, rb, rop, 1'b1);
    e.w = ref_result(ra, rb, rop, 1'b0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid_s, out_valid_w} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_out_valid: got %b, want 00", {out_valid_s, out_valid_w});
    end
    n_checks++;
    if ({got_s, got_w} !== 18'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got %h/%h, want 000/000", got_s, got_w);
    end
    n_checks++;
    if ({in_ready_s, in_ready_w} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %b, want 11", {in_ready_s, in_ready_w});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({out_valid_s, out_valid_w} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: got %b, want 00", {out_valid_s, out_valid_w});
    end
  endtask

  // Single beats with a fixed 2-cycle latency; expectations are hand-derived.
  task automatic test_directed();
    logic [7:0] ta [11] = '{8'h05, 8'h03, 8'h82, 8'h05, 8'h85, 8'h80, 8'h64, 8'hC0, 8'h7F, 8'h85, 8'h03};
    logic [7:0] tb [11] = '{8'h83, 8'h8A, 8'h03, 8'h05, 8'h05, 8'h80, 8'h32, 8'hC0, 8'hFF, 8'h85, 8'h05};
    logic       to [11] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
    logic [8:0] es [11] = '{9'h002, 9'h087, 9'h085, 9'h000, 9'h000, 9'h000, 9'h17F, 9'h1FF, 9'h17F, 9'h000, 9'h082};
    logic [8:0] ew [11] = '{9'h002, 9'h087, 9'h085, 9'h000, 9'h000, 9'h000, 9'h116, 9'h100, 9'h17E, 9'h000, 9'h082};
    for (int i = 0; i < 11; i++) begin
      a         = ta[i];
      b         = tb[i];
      op        = to[i];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready_s !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL dir_in_ready[%0d]: got %b, want 1", i, in_ready_s);
      end
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid_s !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL dir_latency_early[%0d]: got out_valid %b, want 0", i, out_valid_s);
      end
      tick();
      n_checks++;
      if ({out_valid_s, out_valid_w} !== 2'b11) begin
        n_fail++;
        $display("[TB] FAIL dir_latency[%0d]: got out_valid %b, want 11", i, {out_valid_s, out_valid_w});
      end
      n_checks++;
      if (got_s !== es[i]) begin
        n_fail++;
        $display("[TB] FAIL dir_sat[%0d] a=%h b=%h op=%b: got %h, want %h", i, ta[i], tb[i], to[i], got_s, es[i]);
      end
      n_checks++;
      if (got_w !== ew[i]) begin
        n_fail++;
        $display("[TB] FAIL dir_wrap[%0d] a=%h b=%h op=%b: got %h, want %h", i, ta[i], tb[i], to[i], got_w, ew[i]);
      end
    end
    tick();
  endtask

  // Six beats with the output blocked, then released.
  task automatic test_backpressure();
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic       vo [6];
    exp_t       e0;
    exp_t       ex;
    int sent, rcv, first, last, cyc;
    bit acc;
    for (int i = 0; i < 6; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
      vo[i] = 1'($urandom);
    end
    e0        = ref_pair(va[0], vb[0], vo[0]);
    sent      = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      a        = va[sent];
      b        = vb[sent];
      op       = vo[sent];
      #1;
      acc = in_ready_s;
      if (c >= 2) begin
        n_checks++;
        if ({out_valid_s, got_s, got_w} !== {1'b1, e0.s, e0.w}) begin
          n_fail++;
          $display("[TB] FAIL bp_hold[%0d]: got v=%b %h/%h, want v=1 %h/%h", c, out_valid_s, got_s, got_w, e0.s, e0.w);
        end
      end
      tick();
      if (acc) sent++;
    end
    n_checks++;
    if (sent != 2) begin
      n_fail++;
      $display("[TB] FAIL bp_accepted: got %0d, want 2", sent);
    end
    n_checks++;
    if ({in_ready_s, in_ready_w} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL bp_in_ready: got %b, want 00", {in_ready_s, in_ready_w});
    end
    out_ready = 1'b1;
    rcv   = 0;
    first = -1;
    last  = -1;
    cyc   = 0;
    while (rcv < 6 && cyc < 30) begin
      in_valid = (sent < 6);
      if (sent < 6) begin
        a  = va[sent];
        b  = vb[sent];
        op = vo[sent];
      end
      #1;
      acc = in_valid && in_ready_s;
      if (out_valid_s) begin
        ex = ref_pair(va[rcv], vb[rcv], vo[rcv]);
        n_checks++;
        if ({got_s, got_w} !== {ex.s, ex.w}) begin
          n_fail++;
          $display("[TB] FAIL bp_order[%0d]: got %h/%h, want %h/%h", rcv, got_s, got_w, ex.s, ex.w);
        end
        if (first < 0) first = cyc;
        last = cyc;
        rcv++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (rcv != 6 || (last - first) != 5) begin
      n_fail++;
      $display("[TB] FAIL bp_drain: got %0d results over %0d cycles, want 6 over 6", rcv, last - first + 1);
    end
    tick();
    n_checks++;
    if (out_valid_s !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_no_dup: got out_valid %b, want 0", out_valid_s);
    end
  endtask

  // Random valid/ready soak against a queue of expected results.
  task automatic test_soak();
    exp_t q[$];
    exp_t ex;
    bit   exp_ready, acc;
    int   cyc;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      op        = 1'($urandom);
      if (c % 37 == 0) b = a;
      #1;
      exp_ready = (q.size() < 2) || out_ready;
      n_checks++;
      if ({in_ready_s, in_ready_w} !== {exp_ready, exp_ready}) begin
        n_fail++;
        $display("[TB] FAIL soak_in_ready[%0d]: got %b, want %b", c, {in_ready_s, in_ready_w}, {exp_ready, exp_ready});
      end
      if (out_valid_s && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL soak_spurious[%0d]: got result %h, want none", c, got_s);
        end else begin
          ex = q.pop_front();
          if ({got_s, got_w, out_valid_w} !== {ex.s, ex.w, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL soak_data[%0d]: got %h/%h, want %h/%h", c, got_s, got_w, ex.s, ex.w);
          end
        end
      end
      acc = in_valid && in_ready_s;
      if (acc) q.push_back(ref_pair(a, b, op));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      #1;
      if (out_valid_s) begin
        ex = q.pop_front();
        n_checks++;
        if ({got_s, got_w} !== {ex.s, ex.w}) begin
          n_fail++;
          $display("[TB] FAIL soak_drain: got %h/%h, want %h/%h", got_s, got_w, ex.s, ex.w);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL soak_lost: got %0d results missing, want 0", q.size());
    end
  endtask

  // Reset with two beats in flight; nothing may emerge afterwards.
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a        = 8'h11 + 8'(i);
      b        = 8'h22;
      op       = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid_s, in_ready_s} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL mid_full: got v/rdy %b, want 10", {out_valid_s, in_ready_s});
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid_s, out_valid_w, got_s, got_w} !== 20'h0) begin
      n_fail++;
      $display("[TB] FAIL mid_async_clear: got v=%b%b %h/%h, want v=00 000/000", out_valid_s, out_valid_w, got_s, got_w);
    end
    n_checks++;
    if ({in_ready_s, in_ready_w} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL mid_in_ready: got %b, want 11", {in_ready_s, in_ready_w});
    end
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      n_checks++;
      if ({out_valid_s, out_valid_w} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL mid_stale[%0d]: got out_valid %b, want 00", c, {out_valid_s, out_valid_w});
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_soak();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
